// File: rtl/data_packer.sv
// rtl/data_packer.sv - packs kept elements of per-chain result vectors into dense N-wide trace words
module data_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int INITIAL_MODE       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [DATA_WIDTH-1:0]         vector_in [N-1:0],
  output logic [DATA_WIDTH-1:0]         vector_out [N-1:0],
  output logic [$clog2(N+1)-1:0]        valid_count,
  output logic                          valid_out,
  output logic                          eof_out,
  output logic                          overflow_err
);

  localparam int CNTW = $clog2(N);
  localparam int SUMW = $clog2(2 * N);
  localparam int VCW  = $clog2(N + 1);
  localparam int CIW  = $clog2(MAX_CHAINS);

  // Pack buffer: holds 0..N-1 leftover elements between cycles, element 0 oldest.
  logic [DATA_WIDTH-1:0] buf_q [N-1:0];
  logic [CNTW-1:0]       count_q;
  logic                  flush_q;
  logic [7:0]            mode_q [MAX_CHAINS];
  logic [CIW-1:0]        cfg_ptr;

  logic                  accept;
  logic [7:0]            cur_mode;
  logic [SUMW-1:0]       k;
  logic [SUMW-1:0]       sum;
  logic                  emit;
  logic [DATA_WIDTH-1:0] comb_e [2*N];
  logic [DATA_WIDTH-1:0] word_d [N-1:0];
  logic [DATA_WIDTH-1:0] buf_d [N-1:0];
  logic [DATA_WIDTH-1:0] flush_word [N-1:0];
  logic [CNTW-1:0]       count_d;

  // Merge buffered elements with the newly kept ones and split into output word and leftover.
  always_comb begin
    cur_mode = mode_q[chainId_in];
    // Input arriving during a flush cycle is a protocol violation and is discarded.
    accept   = tracing && valid_in && !flush_q;
    k        = '0;
    if (accept) begin
      if (cur_mode == 8'd1)      k = SUMW'(N);
      else if (cur_mode == 8'd2) k = SUMW'(1);
    end
    sum = SUMW'(count_q) + k;
    for (int i = 0; i < 2 * N; i++) comb_e[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (CNTW'(i) < count_q) comb_e[i] = buf_q[i];
    end
    for (int j = 0; j < N; j++) begin
      if (SUMW'(j) < k) comb_e[SUMW'(count_q) + SUMW'(j)] = vector_in[j];
    end
    emit = (sum >= SUMW'(N));
    for (int i = 0; i < N; i++) begin
      word_d[i]     = comb_e[i];
      buf_d[i]      = emit ? comb_e[N + i] : comb_e[i];
      flush_word[i] = (CNTW'(i) < count_q) ? buf_q[i] : '0;
    end
    count_d = emit ? CNTW'(sum - SUMW'(N)) : CNTW'(sum);
  end

  // Config port writes chain modes round-robin, regardless of tracing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ptr <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) mode_q[c] <= 8'(INITIAL_MODE);
    end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      mode_q[cfg_ptr] <= configData;
      cfg_ptr         <= (cfg_ptr == CIW'(MAX_CHAINS - 1)) ? '0 : cfg_ptr + 1'b1;
    end
  end

  // Registered datapath: full-word emission, eof flush of the remainder, sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i]      <= '0;
        vector_out[i] <= '0;
      end
      count_q      <= '0;
      flush_q      <= 1'b0;
      valid_out    <= 1'b0;
      eof_out      <= 1'b0;
      valid_count  <= '0;
      overflow_err <= 1'b0;
    end else if (flush_q) begin
      flush_q     <= 1'b0;
      count_q     <= '0;
      eof_out     <= 1'b1;
      valid_out   <= (count_q != '0);
      valid_count <= VCW'(count_q);
      if (count_q != '0) begin
        for (int i = 0; i < N; i++) vector_out[i] <= flush_word[i];
      end
      if (tracing && (valid_in || eof_in)) overflow_err <= 1'b1;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < N; i++) buf_q[i] <= buf_d[i];
      flush_q     <= tracing && eof_in;
      eof_out     <= 1'b0;
      valid_out   <= emit;
      valid_count <= emit ? VCW'(N) : '0;
      if (emit) begin
        for (int i = 0; i < N; i++) vector_out[i] <= word_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_packer.sv
// tb/tb_data_packer.sv - directed self-checking bench for data_packer
module tb_data_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tracing;
  logic        valid_in;
  logic        eof_in;
  logic [1:0]  chainId_in;
  logic [7:0]  configId;
  logic [7:0]  configData;
  logic [31:0] vector_in [7:0];
  logic [31:0] vector_out [7:0];
  logic [3:0]  valid_count;
  logic        valid_out;
  logic        eof_out;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  data_packer dut (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
    .chainId_in(chainId_in), .configId(configId), .configData(configData),
    .vector_in(vector_in), .vector_out(vector_out), .valid_count(valid_count),
    .valid_out(valid_out), .eof_out(eof_out), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] w8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [255:0] out_word();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = vector_out[i];
    return r;
  endfunction

  task automatic setv(input int base);
    for (int i = 0; i < 8; i++) vector_in[i] = 32'(base + i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] data);
    configId = 8'd0; configData = data; valid_in = 1'b0;
    tick();
    configId = 8'hFF;
  endtask

  task automatic scalar(input logic [1:0] ch, input int val);
    chainId_in = ch; valid_in = 1'b1; setv(val);
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = 1'b0;
    chainId_in = 2'd0; configId = 8'hFF; configData = 8'd0; setv(0);
    tick(); tick();
    check("rst_valid_out", valid_out, 0);
    check("rst_eof_out", eof_out, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_valid_count", valid_count, 0);
    check("rst_vector", out_word(), 0);
    reset = 1'b0; tracing = 1'b1;

    // mode-1 pass-through
    scalar(2'd0, 1);
    check("t1_valid_out", valid_out, 1);
    check("t1_valid_count", valid_count, 8);
    check("t1_word", out_word(), w8(1, 2, 3, 4, 5, 6, 7, 8));
    check("t1_eof", eof_out, 0);
    tick();
    check("t1_idle_valid", valid_out, 0);
    check("t1_hold_word", out_word(), w8(1, 2, 3, 4, 5, 6, 7, 8));

    // all chains to scalar mode
    for (int c = 0; c < 4; c++) cfg(8'd2);
    for (int v = 0; v < 8; v++) begin
      scalar(2'(v % 4), 10 + v);
      if (v < 7) check("t2_no_out", valid_out, 0);
    end
    check("t2_valid_out", valid_out, 1);
    check("t2_valid_count", valid_count, 8);
    check("t2_word", out_word(), w8(10, 11, 12, 13, 14, 15, 16, 17));

    // scalar flush, with an ignored input while tracing is low
    scalar(2'd0, 5);
    scalar(2'd0, 6);
    tracing = 1'b0; valid_in = 1'b1; eof_in = 1'b1; setv(99);
    tick();
    check("t3_trace_off_valid", valid_out, 0);
    tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0;
    tick();
    check("t3_trace_off_eof", eof_out, 0);
    scalar(2'd0, 7);
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
    check("t3_eof_t1_valid", valid_out, 0);
    check("t3_eof_t1_eof", eof_out, 0);
    tick();
    check("t3_flush_valid", valid_out, 1);
    check("t3_flush_eof", eof_out, 1);
    check("t3_flush_count", valid_count, 3);
    check("t3_flush_word", out_word(), w8(5, 6, 7, 0, 0, 0, 0, 0));
    tick();
    check("t3_after_eof", eof_out, 0);

    // mixed scalars and a full vector; cfg_ptr is back at chain 0
    cfg(8'd2);
    cfg(8'd1);
    scalar(2'd0, 5);
    scalar(2'd0, 6);
    scalar(2'd0, 7);
    scalar(2'd1, 1);
    check("t4_valid_out", valid_out, 1);
    check("t4_word", out_word(), w8(5, 6, 7, 1, 2, 3, 4, 5));
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
    tick();
    check("t4_flush_word", out_word(), w8(6, 7, 8, 0, 0, 0, 0, 0));
    check("t4_flush_count", valid_count, 3);
    check("t4_flush_eof", eof_out, 1);

    // eof on an empty buffer
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
    tick();
    check("eof_empty_valid", valid_out, 0);
    check("eof_empty_count", valid_count, 0);
    check("eof_empty_eof", eof_out, 1);

    // eof together with a valid scalar
    chainId_in = 2'd0; valid_in = 1'b1; eof_in = 1'b1; setv(9);
    tick();
    valid_in = 1'b0; eof_in = 1'b0;
    check("eof_with_data_t1", valid_out, 0);
    tick();
    check("eof_with_data_word", out_word(), w8(9, 0, 0, 0, 0, 0, 0, 0));
    check("eof_with_data_count", valid_count, 1);

    // protocol violation: valid input in the flush cycle
    scalar(2'd0, 4);
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
    chainId_in = 2'd1; valid_in = 1'b1; setv(50);
    tick();
    valid_in = 1'b0;
    check("t5_flush_word", out_word(), w8(4, 0, 0, 0, 0, 0, 0, 0));
    check("t5_flush_count", valid_count, 1);
    check("t5_overflow", overflow_err, 1);
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
    tick();
    check("t5_dropped_valid", valid_out, 0);
    check("t5_dropped_count", valid_count, 0);
    check("t5_overflow_sticky", overflow_err, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_overflow", overflow_err, 0);

    // config after reset: chain0 drop, chain1 scalar, ignored config for chain2
    cfg(8'd0);
    cfg(8'd2);
    configId = 8'd3; configData = 8'd7;
    scalar(2'd0, 200);
    configId = 8'hFF;
    check("t6_drop_valid", valid_out, 0);
    for (int v = 0; v < 5; v++) scalar(2'd1, 21 + v);
    check("t6_scalars_no_out", valid_out, 0);
    scalar(2'd2, 1);
    check("t6_word", out_word(), w8(21, 22, 23, 24, 25, 1, 2, 3));
    check("t6_word_count", valid_count, 8);
    // asynchronous reset with five elements buffered
    reset = 1'b1;
    #1;
    check("t6_async_valid", valid_out, 0);
    check("t6_async_count", valid_count, 0);
    check("t6_async_word", out_word(), 0);
    reset = 1'b0;
    scalar(2'd0, 100);
    check("t6_post_valid", valid_out, 1);
    check("t6_post_word", out_word(), w8(100, 101, 102, 103, 104, 105, 106, 107));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
